// File: rtl/sev_seg_display_n.sv
`default_nettype none
// ============================================================================
// Module      : sev_seg_display_n
// Description : Multi-digit 7-segment controller with serial double-dabble
//               conversion, leading-zero blanking and multiplexed refresh.
// Revision    : 1.0 - initial release
// ============================================================================
module sev_seg_display_n #(
    parameter int NUM_DIGITS     = 4,
    parameter int VALUE_W        = 14,
    parameter int REFRESH_DIV    = 25000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] anode
);

    localparam int         BCD_W      = NUM_DIGITS * 4;
    localparam int         CNT_W      = $clog2(VALUE_W + 1);
    localparam int         REF_W      = $clog2(REFRESH_DIV);
    localparam int         IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] GLYPH_DASH = 7'b1000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [VALUE_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [BCD_W-1:0]      digits_q, digits_d;
    logic                  overflow_q, overflow_d;

    logic [REF_W-1:0]      ref_q, ref_d;
    logic                  tick;
    logic                  act_q, act_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [NUM_DIGITS-1:0] dark;
    logic [3:0]            cur_digit;
    logic                  cur_dark;
    logic [6:0]            seg_on;
    logic                  dp_on;
    logic [NUM_DIGITS-1:0] an_on;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] anode_q;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b0111111;
            4'd1:    glyph = 7'b0000110;
            4'd2:    glyph = 7'b1011011;
            4'd3:    glyph = 7'b1001111;
            4'd4:    glyph = 7'b1100110;
            4'd5:    glyph = 7'b1101101;
            4'd6:    glyph = 7'b1111101;
            4'd7:    glyph = 7'b0000111;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1101111;
            default: glyph = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    bin_d   = value_in;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(VALUE_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A one leaving the top nibble means the value needs another digit.
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[VALUE_W-1]};
                bin_d = bin_q << 1;
                ovf_d = ovf_q | bcd_adj[BCD_W-1];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                digits_d   = bcd_q;
                overflow_d = ovf_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        dark       = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (digits_q[4*i +: 4] == 4'd0);
            if (i > 0) begin
                dark[i] = blank_lz & ~overflow_q & upper_zero;
            end
        end
    end

    // The first tick only switches the display on; later ticks advance the digit.
    always_comb begin
        tick  = (ref_q == REF_W'(REFRESH_DIV - 1));
        ref_d = tick ? '0 : ref_q + 1'b1;
        act_d = act_q | tick;
        sel_d = sel_q;
        if (tick && act_q) begin
            sel_d = (sel_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : sel_q + 1'b1;
        end
    end

    always_comb begin
        cur_digit = digits_q[4*sel_d +: 4];
        cur_dark  = dark[sel_d];
        seg_on    = 7'b0000000;
        dp_on     = 1'b0;
        an_on     = '0;
        if (act_d) begin
            an_on[sel_d] = 1'b1;
            if (overflow_q) begin
                seg_on = GLYPH_DASH;
            end else if (!cur_dark) begin
                seg_on = glyph(cur_digit);
            end
            dp_on = ~cur_dark & dp_mask[sel_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q   <= '0;
            act_q   <= 1'b0;
            sel_q   <= '0;
            seg_q   <= {7{SEG_ACTIVE_LOW}};
            dp_q    <= SEG_ACTIVE_LOW;
            anode_q <= {NUM_DIGITS{AN_ACTIVE_LOW}};
        end else begin
            ref_q   <= ref_d;
            act_q   <= act_d;
            sel_q   <= sel_d;
            seg_q   <= seg_on ^ {7{SEG_ACTIVE_LOW}};
            dp_q    <= dp_on ^ SEG_ACTIVE_LOW;
            anode_q <= an_on ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign overflow = overflow_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign anode    = anode_q;

endmodule
`default_nettype wire

// File: tb/tb_sev_seg_display_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_sev_seg_display_n
// Description : Self-checking bench for sev_seg_display_n (two configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sev_seg_display_n;

    localparam int ND0 = 4, VW0 = 14, RD0 = 8;
    localparam int ND1 = 6, VW1 = 20, RD1 = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [VW0-1:0] value_u0 = '0;
    logic           load_u0  = 1'b0, blz_u0 = 1'b0;
    logic [ND0-1:0] mask_u0  = '0;
    logic           busy_u0, ovf_u0, dp_u0;
    logic [6:0]     seg_u0;
    logic [ND0-1:0] an_u0;

    logic [VW1-1:0] value_u1 = '0;
    logic           load_u1  = 1'b0, blz_u1 = 1'b0;
    logic [ND1-1:0] mask_u1  = '0;
    logic           busy_u1, ovf_u1, dp_u1;
    logic [6:0]     seg_u1;
    logic [ND1-1:0] an_u1;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    sev_seg_display_n #(.NUM_DIGITS(ND0), .VALUE_W(VW0), .REFRESH_DIV(RD0),
                        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u0 (
        .clk(clk), .rst(rst), .value_in(value_u0), .load(load_u0),
        .blank_lz(blz_u0), .dp_mask(mask_u0), .busy(busy_u0),
        .overflow(ovf_u0), .seg(seg_u0), .dp(dp_u0), .anode(an_u0));

    sev_seg_display_n #(.NUM_DIGITS(ND1), .VALUE_W(VW1), .REFRESH_DIV(RD1),
                        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)) u1 (
        .clk(clk), .rst(rst), .value_in(value_u1), .load(load_u1),
        .blank_lz(blz_u1), .dp_mask(mask_u1), .busy(busy_u1),
        .overflow(ovf_u1), .seg(seg_u1), .dp(dp_u1), .anode(an_u1));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph_of(input longint d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic longint pow10(input int e);
        longint p = 1;
        for (int j = 0; j < e; j++) p = p * 10;
        return p;
    endfunction

    // Output expected after the n-th clock since reset release, from the
    // displayed value and the live controls seen at that clock.
    function automatic void model_out(input int nd, input int rd, input int n,
                                      input longint val, input bit ovf, input bit blz,
                                      input logic [7:0] mask, input bit sal,
                                      output logic [6:0] s, output logic dpo,
                                      output logic [7:0] an);
        int     d;
        bit     drk;
        longint p;
        logic [7:0] on;
        s = 7'b0; dpo = 1'b0; on = 8'b0;
        if (n >= rd) begin
            d     = ((n - rd) / rd) % nd;
            p     = pow10(d);
            on[d] = 1'b1;
            drk   = blz && !ovf && d > 0 && val < p;
            if (ovf) s = 7'b1000000;
            else if (!drk) s = glyph_of((val / p) % 10);
            dpo = !drk && mask[d];
        end
        if (sal) begin
            s   = ~s;
            dpo = ~dpo;
        end
        an = 8'((1 << nd) - 1) & ~on;
    endfunction

    int         n_cyc [2];
    int         bl    [2];
    longint     pend  [2];
    longint     disp  [2];
    bit         movf  [2];
    logic [6:0] e_seg [2];
    logic       e_dp  [2];
    logic [7:0] e_an  [2];
    logic       e_busy[2];
    logic       e_ovf [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int         nd, rd, vw;
            bit         sal, ld, blz;
            longint     v;
            logic [7:0] mask;
            nd   = (k == 0) ? ND0 : ND1;
            rd   = (k == 0) ? RD0 : RD1;
            vw   = (k == 0) ? VW0 : VW1;
            sal  = (k == 0);
            ld   = (k == 0) ? load_u0 : load_u1;
            blz  = (k == 0) ? blz_u0 : blz_u1;
            v    = (k == 0) ? longint'(value_u0) : longint'(value_u1);
            mask = (k == 0) ? {4'b0, mask_u0} : {2'b0, mask_u1};
            if (rst) begin
                n_cyc[k] = 0; bl[k] = 0; disp[k] = 0; movf[k] = 1'b0;
                model_out(nd, rd, 0, 0, 1'b0, 1'b0, 8'b0, sal, e_seg[k], e_dp[k], e_an[k]);
            end else begin
                n_cyc[k]++;
                model_out(nd, rd, n_cyc[k], disp[k], movf[k], blz, mask, sal,
                          e_seg[k], e_dp[k], e_an[k]);
                if (bl[k] == 0) begin
                    if (ld) begin
                        pend[k] = v;
                        bl[k]   = vw + 1;
                    end
                end else begin
                    bl[k]--;
                    if (bl[k] == 0) begin
                        disp[k] = pend[k];
                        movf[k] = (pend[k] >= pow10(nd));
                    end
                end
            end
            e_busy[k] = (bl[k] != 0);
            e_ovf[k]  = movf[k];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy0", 32'(busy_u0), 32'(e_busy[0]));
            check("ovf0",  32'(ovf_u0),  32'(e_ovf[0]));
            check("seg0",  32'(seg_u0),  32'(e_seg[0]));
            check("dp0",   32'(dp_u0),   32'(e_dp[0]));
            check("an0",   32'(an_u0),   32'(e_an[0][3:0]));
            check("busy1", 32'(busy_u1), 32'(e_busy[1]));
            check("ovf1",  32'(ovf_u1),  32'(e_ovf[1]));
            check("seg1",  32'(seg_u1),  32'(e_seg[1]));
            check("dp1",   32'(dp_u1),   32'(e_dp[1]));
            check("an1",   32'(an_u1),   32'(e_an[1][5:0]));
        end
    end

    task automatic do_load(input int k, input longint v);
        @(negedge clk);
        if (k == 0) begin value_u0 = VW0'(v); load_u0 = 1'b1; end
        else        begin value_u1 = VW1'(v); load_u1 = 1'b1; end
        @(negedge clk);
        load_u0 = 1'b0;
        load_u1 = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (k == 0) ? !busy_u0 : !busy_u1;
        end
        if (!done) begin
            n_assert++; n_fail++;
            $display("FAIL wait_idle: unit %0d still busy", k);
        end
        @(negedge clk);
    endtask

    task automatic wait_an(input int k, input int d);
        logic [3:0] p0;
        logic [5:0] p1;
        bit         hit = 1'b0;
        p0 = ~(4'b0001 << d);
        p1 = ~(6'b000001 << d);
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = (k == 0) ? (an_u0 == p0) : (an_u1 == p1);
        end
        if (!hit) begin
            n_assert++; n_fail++;
            $display("FAIL wait_anode: unit %0d digit %0d never lit (anodes %0h %0h)", k, d, an_u0, an_u1);
        end
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b0;

        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (an_u0 == 4'hF && cnt < 100);
        check("first_on_cycles", 32'(cnt), 32'(RD0));
        check("first_anode", 32'(an_u0), 32'(4'b1110));

        do_load(0, 1234);
        cnt = 0;
        while (busy_u0 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(cnt), 32'(15));
        @(negedge clk);
        wait_an(0, 3); check("d3_1234", 32'(seg_u0), 32'(7'b1111001));
        wait_an(0, 0); check("d0_1234", 32'(seg_u0), 32'(7'b0011001));

        do_load(0, 9999); wait_idle(0);
        check("ovf_9999", 32'(ovf_u0), 32'(0));
        wait_an(0, 0); check("d0_9999", 32'(seg_u0), 32'(7'b0010000));

        mask_u0 = 4'b1000;
        do_load(0, 10000); wait_idle(0);
        check("ovf_10000", 32'(ovf_u0), 32'(1));
        wait_an(0, 2); check("dash_d2", 32'(seg_u0), 32'(7'b0111111));
        wait_an(0, 3); check("dp_d3_ovf", 32'(dp_u0), 32'(0));

        blz_u0 = 1'b1;
        do_load(0, 7); wait_idle(0);
        wait_an(0, 3);
        check("dark_d3", 32'(seg_u0), 32'(7'h7F));
        check("dark_dp3", 32'(dp_u0), 32'(1));
        wait_an(0, 0); check("d0_7", 32'(seg_u0), 32'(7'b1111000));
        do_load(0, 0); wait_idle(0);
        wait_an(0, 1); check("d1_dark0", 32'(seg_u0), 32'(7'h7F));
        wait_an(0, 0); check("d0_zero", 32'(seg_u0), 32'(7'b1000000));
        blz_u0 = 1'b0;
        wait_an(0, 3); check("d3_0007", 32'(seg_u0), 32'(7'b1000000));

        mask_u0 = 4'b0000;
        do_load(0, 42);
        repeat (3) @(negedge clk);
        do_load(0, 9);
        wait_idle(0);
        repeat (20) @(negedge clk);
        check("busy_after_42", 32'(busy_u0), 32'(0));
        wait_an(0, 0); check("d0_42", 32'(seg_u0), 32'(7'b0100100));
        wait_an(0, 1); check("d1_42", 32'(seg_u0), 32'(7'b0011001));

        mask_u1 = 6'b000100;
        do_load(1, 999999); wait_idle(1);
        check("u1_ovf_999999", 32'(ovf_u1), 32'(0));
        wait_an(1, 2);
        check("u1_d2", 32'(seg_u1), 32'(7'b1101111));
        check("u1_dp2", 32'(dp_u1), 32'(1));
        wait_an(1, 1); check("u1_d1_dp", 32'(dp_u1), 32'(0));
        do_load(1, 1000000); wait_idle(1);
        check("u1_ovf", 32'(ovf_u1), 32'(1));

        do_load(0, 1234);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("busy_rst", 32'(busy_u0), 32'(0));
        check("ovf_rst", 32'(ovf_u1), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        wait_an(0, 3); check("d3_after_rst", 32'(seg_u0), 32'(7'b1000000));
        wait_an(0, 0); check("d0_after_rst", 32'(seg_u0), 32'(7'b1000000));
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
